// File: rtl/fu_dispatch.sv
// Single-entry dispatch stage for the execute side: one instruction is held, handed to exactly
// one functional unit when it can take it, and its transaction ID is tracked until writeback.
package fu_dispatch_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        FU_NONE   = 4'd0,
        FU_ALU    = 4'd1,
        FU_BRANCH = 4'd2,
        FU_CSR    = 4'd3,
        FU_MULT   = 4'd4,
        FU_LOAD   = 4'd5,
        FU_STORE  = 4'd6,
        FU_DUMMY  = 4'd7,
        FU_FPU    = 4'd8
    } fu_t;

    typedef struct packed {
        logic [7:0]               operation;
        logic [31:0]              operand_a;
        logic [31:0]              operand_b;
        logic [31:0]              imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

endpackage

module fu_dispatch
    import fu_dispatch_pkg::*;
#(
    parameter int unsigned TRANS_ID_BITS = fu_dispatch_pkg::TRANS_ID_BITS,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,

    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [3:0]                  issue_fu_i,
    input  fu_data_t                    issue_data_i,

    input  logic                        flu_ready_i,
    input  logic                        lsu_ready_i,
    input  logic                        dummy_FU_ready_i,
    input  logic                        fpu_ready_i,

    output fu_data_t                    fu_data_o,
    output logic                        alu_valid_o,
    output logic                        branch_valid_o,
    output logic                        csr_valid_o,
    output logic                        mult_valid_o,
    output logic                        lsu_valid_o,
    output logic                        dummy_FU_valid_o,
    output logic                        fpu_valid_o,

    input  logic                        flu_wb_valid_i,
    input  logic                        load_wb_valid_i,
    input  logic                        store_wb_valid_i,
    input  logic                        dummy_FU_wb_valid_i,
    input  logic                        fpu_wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0]    flu_wb_id_i,
    input  logic [TRANS_ID_BITS-1:0]    load_wb_id_i,
    input  logic [TRANS_ID_BITS-1:0]    store_wb_id_i,
    input  logic [TRANS_ID_BITS-1:0]    dummy_FU_wb_id_i,
    input  logic [TRANS_ID_BITS-1:0]    fpu_wb_id_i,

    output logic [2**TRANS_ID_BITS-1:0] pending_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    localparam int unsigned NUM_IDS = 2**TRANS_ID_BITS;

    logic                     stage_full_q;
    fu_t                      stage_fu_q;
    fu_data_t                 fu_data_q;
    logic [NUM_IDS-1:0]       pending_q;
    logic [NUM_IDS-1:0]       pending_d;
    logic                     mult_hazard_q;
    logic [CNT_W-1:0]         stall_cnt_q;

    logic [TRANS_ID_BITS-1:0] stage_id;
    logic                     unit_ready;
    logic                     flu_port_blocked;
    logic                     fire;
    logic                     accept;

    // Undefined unit codes are folded to NONE on entry so the rest of the stage sees a legal fu_t.
    function automatic fu_t decode_fu(input logic [3:0] raw);
        if (raw > 4'd8) begin
            return FU_NONE;
        end
        return fu_t'(raw);
    endfunction

    assign stage_id = fu_data_q.trans_id;

    always_comb begin
        // NOTE: default assignment first so every path drives unit_ready and no latch is inferred.
        unit_ready = 1'b1;
        case (stage_fu_q)
            FU_ALU, FU_BRANCH, FU_CSR, FU_MULT: unit_ready = flu_ready_i;
            FU_LOAD, FU_STORE:                 unit_ready = lsu_ready_i;
            FU_DUMMY:                          unit_ready = dummy_FU_ready_i;
            FU_FPU:                            unit_ready = fpu_ready_i;
            default:                           unit_ready = 1'b1;
        endcase
    end

    // The cycle after a MULT dispatch, its result owns the shared FLU writeback port.
    assign flu_port_blocked = mult_hazard_q &
                              ((stage_fu_q == FU_ALU) | (stage_fu_q == FU_BRANCH) |
                               (stage_fu_q == FU_CSR));

    assign fire = stage_full_q & ~flush_i & unit_ready & ~pending_q[stage_id] & ~flu_port_blocked;

    assign issue_ready_o = ~flush_i & (~stage_full_q | fire);
    assign accept        = issue_valid_i & issue_ready_o;

    assign alu_valid_o      = fire & (stage_fu_q == FU_ALU);
    assign branch_valid_o   = fire & (stage_fu_q == FU_BRANCH);
    assign csr_valid_o      = fire & (stage_fu_q == FU_CSR);
    assign mult_valid_o     = fire & (stage_fu_q == FU_MULT);
    assign lsu_valid_o      = fire & ((stage_fu_q == FU_LOAD) | (stage_fu_q == FU_STORE));
    assign dummy_FU_valid_o = fire & (stage_fu_q == FU_DUMMY);
    assign fpu_valid_o      = fire & (stage_fu_q == FU_FPU);

    // Retires first, then the new dispatch; the two never hit the same ID since fire needs ~pending.
    always_comb begin
        pending_d = pending_q;
        if (flu_wb_valid_i)      pending_d[flu_wb_id_i]      = 1'b0;
        if (load_wb_valid_i)     pending_d[load_wb_id_i]     = 1'b0;
        if (store_wb_valid_i)    pending_d[store_wb_id_i]    = 1'b0;
        if (dummy_FU_wb_valid_i) pending_d[dummy_FU_wb_id_i] = 1'b0;
        if (fpu_wb_valid_i)      pending_d[fpu_wb_id_i]      = 1'b0;
        if (fire && (stage_fu_q != FU_NONE)) begin
            pending_d[stage_id] = 1'b1;
        end
        if (flush_i) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_full_q  <= 1'b0;
            stage_fu_q    <= FU_NONE;
            fu_data_q     <= '0;
            pending_q     <= '0;
            mult_hazard_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            pending_q     <= pending_d;
            mult_hazard_q <= fire & (stage_fu_q == FU_MULT);

            if (stage_full_q && !fire && !flush_i && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            if (flush_i) begin
                stage_full_q <= 1'b0;
            end else if (accept) begin
                stage_full_q <= 1'b1;
                stage_fu_q   <= decode_fu(issue_fu_i);
                fu_data_q    <= issue_data_i;
            end else if (fire) begin
                stage_full_q <= 1'b0;
            end
        end
    end

    assign fu_data_o   = fu_data_q;
    assign pending_o   = pending_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fu_dispatch.sv
// Bench for fu_dispatch: directed scenarios with fixed expectations, then random traffic
// compared against a transaction-level model of the dispatch stage.
module tb_fu_dispatch;
    import fu_dispatch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [3:0]  issue_fu_i = 4'd0;
    fu_data_t    issue_data_i = '0;
    logic        flu_ready_i = 1'b0, lsu_ready_i = 1'b0, dummy_FU_ready_i = 1'b0, fpu_ready_i = 1'b0;
    fu_data_t    fu_data_o;
    logic        alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o;
    logic        lsu_valid_o, dummy_FU_valid_o, fpu_valid_o;
    logic        flu_wb_valid_i = 1'b0, load_wb_valid_i = 1'b0, store_wb_valid_i = 1'b0;
    logic        dummy_FU_wb_valid_i = 1'b0, fpu_wb_valid_i = 1'b0;
    logic [2:0]  flu_wb_id_i = 3'd0, load_wb_id_i = 3'd0, store_wb_id_i = 3'd0;
    logic [2:0]  dummy_FU_wb_id_i = 3'd0, fpu_wb_id_i = 3'd0;
    logic [7:0]  pending_o;
    logic [31:0] stall_cnt_o;
    logic [6:0]  valid_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: the held instruction (if any), the set of busy IDs, and counters.
    bit          m_full;
    int          m_fu;
    fu_data_t    m_data;
    bit          m_pend [8];
    bit          m_hazard;
    logic [31:0] m_stall;

    fu_dispatch #(.TRANS_ID_BITS(3), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_fu_i(issue_fu_i), .issue_data_i(issue_data_i),
        .flu_ready_i(flu_ready_i), .lsu_ready_i(lsu_ready_i),
        .dummy_FU_ready_i(dummy_FU_ready_i), .fpu_ready_i(fpu_ready_i),
        .fu_data_o(fu_data_o),
        .alu_valid_o(alu_valid_o), .branch_valid_o(branch_valid_o), .csr_valid_o(csr_valid_o),
        .mult_valid_o(mult_valid_o), .lsu_valid_o(lsu_valid_o),
        .dummy_FU_valid_o(dummy_FU_valid_o), .fpu_valid_o(fpu_valid_o),
        .flu_wb_valid_i(flu_wb_valid_i), .load_wb_valid_i(load_wb_valid_i),
        .store_wb_valid_i(store_wb_valid_i), .dummy_FU_wb_valid_i(dummy_FU_wb_valid_i),
        .fpu_wb_valid_i(fpu_wb_valid_i),
        .flu_wb_id_i(flu_wb_id_i), .load_wb_id_i(load_wb_id_i), .store_wb_id_i(store_wb_id_i),
        .dummy_FU_wb_id_i(dummy_FU_wb_id_i), .fpu_wb_id_i(fpu_wb_id_i),
        .pending_o(pending_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign valid_vec = {alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o,
                        lsu_valid_o, dummy_FU_valid_o, fpu_valid_o};

    // Valid-vector bit order: {alu, branch, csr, mult, lsu, dummy, fpu}.
    function automatic logic [6:0] onehot_for(input int fu);
        case (fu)
            1:       return 7'b1000000;
            2:       return 7'b0100000;
            3:       return 7'b0010000;
            4:       return 7'b0001000;
            5, 6:    return 7'b0000100;
            7:       return 7'b0000010;
            8:       return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit unit_can_take(input int fu);
        case (fu)
            1, 2, 3, 4: return flu_ready_i;
            5, 6:       return lsu_ready_i;
            7:          return dummy_FU_ready_i;
            8:          return fpu_ready_i;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic fu_data_t mk_data(input int id);
        fu_data_t d;
        d.operation = 8'($urandom);
        d.operand_a = $urandom;
        d.operand_b = $urandom;
        d.imm       = $urandom;
        d.trans_id  = 3'(id);
        return d;
    endfunction

    task automatic model_reset();
        m_full   = 1'b0;
        m_fu     = 0;
        m_data   = '0;
        m_hazard = 1'b0;
        m_stall  = '0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endtask

    task automatic model_eval(output bit fire, output bit rdy, output logic [6:0] vv,
                              output logic [7:0] pend);
        bool_blk: begin
            bit flu_busy;
            flu_busy = m_hazard && (m_fu >= 1 && m_fu <= 3);
            fire = m_full && !flush_i && unit_can_take(m_fu) && !m_pend[m_data.trans_id] && !flu_busy;
        end
        rdy  = !flush_i && (!m_full || fire);
        vv   = fire ? onehot_for(m_fu) : 7'b0;
        for (int i = 0; i < 8; i++) pend[i] = m_pend[i];
    endtask

    task automatic model_update(input bit fire, input bit rdy);
        if (m_full && !fire && !flush_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (flush_i) begin
            m_full   = 1'b0;
            m_hazard = 1'b0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else begin
            m_hazard = fire && (m_fu == 4);
            if (flu_wb_valid_i)      m_pend[flu_wb_id_i]      = 1'b0;
            if (load_wb_valid_i)     m_pend[load_wb_id_i]     = 1'b0;
            if (store_wb_valid_i)    m_pend[store_wb_id_i]    = 1'b0;
            if (dummy_FU_wb_valid_i) m_pend[dummy_FU_wb_id_i] = 1'b0;
            if (fpu_wb_valid_i)      m_pend[fpu_wb_id_i]      = 1'b0;
            if (fire && m_fu >= 1 && m_fu <= 8) m_pend[m_data.trans_id] = 1'b1;
            if (issue_valid_i && rdy) begin
                m_full = 1'b1;
                m_fu   = (issue_fu_i > 4'd8) ? 0 : int'(issue_fu_i);
                m_data = issue_data_i;
            end else if (fire) begin
                m_full = 1'b0;
            end
        end
    endtask

    task automatic next_clk();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i = 0; issue_valid_i = 0; issue_fu_i = 0; issue_data_i = '0;
        flu_ready_i = 0; lsu_ready_i = 0; dummy_FU_ready_i = 0; fpu_ready_i = 0;
        flu_wb_valid_i = 0; load_wb_valid_i = 0; store_wb_valid_i = 0;
        dummy_FU_wb_valid_i = 0; fpu_wb_valid_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic issue(input int fu, input int id);
        issue_valid_i = 1'b1;
        issue_fu_i    = 4'(fu);
        issue_data_i  = mk_data(id);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready_o); end
        checks++; if (valid_vec !== 7'b0) begin errors++; $display("FAIL reset_valids: got %b want 0", valid_vec); end
        checks++; if (pending_o !== 8'h00 || stall_cnt_o !== 32'd0 || fu_data_o !== '0) begin
            errors++; $display("FAIL reset_state: pending %h stall %0d data %h, want all zero", pending_o, stall_cnt_o, fu_data_o);
        end
        next_clk();
    endtask

    task automatic test_alu_basic();
        fu_data_t d;
        do_reset();
        flu_ready_i = 1'b1;
        issue(1, 2);
        d = issue_data_i;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0) begin errors++; $display("FAIL alu_latency: got %b want 0", valid_vec); end
        next_clk();
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b1000000) begin errors++; $display("FAIL alu_fire: got %b want 1000000", valid_vec); end
        checks++; if (fu_data_o !== d) begin errors++; $display("FAIL alu_data: got %h want %h", fu_data_o, d); end
        next_clk();
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0 || pending_o !== 8'h04) begin
            errors++; $display("FAIL alu_pending: valids %b pending %h want 0 / 04", valid_vec, pending_o);
        end
        next_clk();
        flu_wb_valid_i = 1'b1; flu_wb_id_i = 3'd2;
        @(negedge clk_i);
        checks++; if (pending_o !== 8'h04) begin errors++; $display("FAIL alu_wb_same_cycle: got %h want 04", pending_o); end
        next_clk();
        flu_wb_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL alu_retire: got %h want 00", pending_o); end
        next_clk();
    endtask

    task automatic test_mult_hazard();
        do_reset();
        flu_ready_i = 1'b1;
        issue(4, 1);
        next_clk();
        issue(1, 3);
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0001000 || issue_ready_o !== 1'b1) begin
            errors++; $display("FAIL mult_fire: valids %b ready %b want 0001000 / 1", valid_vec, issue_ready_o);
        end
        next_clk();
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0) begin errors++; $display("FAIL mult_blocks_alu: got %b want 0", valid_vec); end
        next_clk();
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b1000000) begin errors++; $display("FAIL alu_after_mult: got %b want 1000000", valid_vec); end
        next_clk();

        do_reset();
        flu_ready_i = 1'b1; lsu_ready_i = 1'b1;
        issue(4, 1);
        next_clk();
        issue(6, 4);
        next_clk();
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0000100) begin errors++; $display("FAIL store_after_mult: got %b want 0000100", valid_vec); end
        next_clk();
    endtask

    task automatic test_lsu_stall();
        do_reset();
        issue(5, 5);
        next_clk();
        issue_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++; if (valid_vec !== 7'b0 || issue_ready_o !== 1'b0) begin
                errors++; $display("FAIL lsu_stall_%0d: valids %b ready %b want 0 / 0", i, valid_vec, issue_ready_o);
            end
            next_clk();
        end
        lsu_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0000100 || stall_cnt_o !== 32'd4) begin
            errors++; $display("FAIL lsu_release: valids %b stall %0d want 0000100 / 4", valid_vec, stall_cnt_o);
        end
        next_clk();
        @(negedge clk_i);
        checks++; if (stall_cnt_o !== 32'd4 || pending_o !== 8'h20) begin
            errors++; $display("FAIL lsu_after: stall %0d pending %h want 4 / 20", stall_cnt_o, pending_o);
        end
        next_clk();
    endtask

    task automatic test_pending_reuse();
        do_reset();
        lsu_ready_i = 1'b1;
        issue(6, 4);
        next_clk();
        issue(5, 4);
        next_clk();
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0) begin errors++; $display("FAIL reuse_blocked: got %b want 0", valid_vec); end
        next_clk();
        load_wb_valid_i = 1'b1; load_wb_id_i = 3'd4;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0 || pending_o !== 8'h10) begin
            errors++; $display("FAIL reuse_no_bypass: valids %b pending %h want 0 / 10", valid_vec, pending_o);
        end
        next_clk();
        load_wb_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0000100) begin errors++; $display("FAIL reuse_fire: got %b want 0000100", valid_vec); end
        next_clk();
    endtask

    task automatic test_flush();
        do_reset();
        dummy_FU_ready_i = 1'b1; fpu_ready_i = 1'b1;
        issue(7, 0);
        next_clk();
        issue(8, 6);
        next_clk();
        issue(1, 2);
        next_clk();
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (pending_o !== 8'h41 || valid_vec !== 7'b0) begin
            errors++; $display("FAIL flush_setup: pending %h valids %b want 41 / 0", pending_o, valid_vec);
        end
        next_clk();
        flush_i = 1'b1; flu_ready_i = 1'b1;
        issue(7, 3);
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0 || issue_ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: valids %b ready %b want 0 / 0", valid_vec, issue_ready_o);
        end
        next_clk();
        flush_i = 1'b0; issue_valid_i = 1'b0; flu_ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (pending_o !== 8'h00 || issue_ready_o !== 1'b1 || valid_vec !== 7'b0 || stall_cnt_o !== 32'd1) begin
            errors++; $display("FAIL flush_after: pending %h ready %b valids %b stall %0d want 00 / 1 / 0 / 1",
                               pending_o, issue_ready_o, valid_vec, stall_cnt_o);
        end
        next_clk();
    endtask

    task automatic test_back_to_back();
        do_reset();
        flu_ready_i = 1'b1; lsu_ready_i = 1'b1; dummy_FU_ready_i = 1'b1; fpu_ready_i = 1'b1;
        issue(7, 1);
        next_clk();
        issue(8, 2);
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0000010) begin errors++; $display("FAIL b2b_dummy: got %b want 0000010", valid_vec); end
        next_clk();
        issue(0, 3);
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0000001) begin errors++; $display("FAIL b2b_fpu: got %b want 0000001", valid_vec); end
        next_clk();
        issue(1, 5);
        @(negedge clk_i);
        checks++; if (valid_vec !== 7'b0 || issue_ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_none: valids %b ready %b want 0 / 1", valid_vec, issue_ready_o);
        end
        next_clk();
        issue_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (pending_o !== 8'h06 || valid_vec !== 7'b1000000) begin
            errors++; $display("FAIL b2b_pending: pending %h valids %b want 06 / 1000000", pending_o, valid_vec);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (valid_vec !== 7'b0 || pending_o !== 8'h00 || fu_data_o !== '0 || stall_cnt_o !== 32'd0) begin
            errors++; $display("FAIL async_reset: valids %b pending %h stall %0d data %h want all zero",
                               valid_vec, pending_o, stall_cnt_o, fu_data_o);
        end
        next_clk();
        rst_ni = 1'b1;
        model_reset();
        next_clk();
    endtask

    task automatic test_random();
        bit         fire, rdy;
        logic [6:0] vv;
        logic [7:0] pend;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            flush_i          = ($urandom_range(0, 24) == 0);
            issue_valid_i    = ($urandom_range(0, 3) != 0);
            issue_fu_i       = 4'($urandom_range(0, 15));
            issue_data_i     = mk_data($urandom_range(0, 7));
            flu_ready_i      = ($urandom_range(0, 3) != 0);
            lsu_ready_i      = ($urandom_range(0, 2) != 0);
            dummy_FU_ready_i = ($urandom_range(0, 2) != 0);
            fpu_ready_i      = ($urandom_range(0, 2) != 0);
            flu_wb_valid_i      = $urandom_range(0, 1) != 0;
            load_wb_valid_i     = $urandom_range(0, 1) != 0;
            store_wb_valid_i    = $urandom_range(0, 2) == 0;
            dummy_FU_wb_valid_i = $urandom_range(0, 2) == 0;
            fpu_wb_valid_i      = $urandom_range(0, 2) == 0;
            flu_wb_id_i      = 3'($urandom_range(0, 7));
            load_wb_id_i     = 3'($urandom_range(0, 7));
            store_wb_id_i    = 3'($urandom_range(0, 7));
            dummy_FU_wb_id_i = 3'($urandom_range(0, 7));
            fpu_wb_id_i      = 3'($urandom_range(0, 7));
            @(negedge clk_i);
            model_eval(fire, rdy, vv, pend);
            checks++; if (issue_ready_o !== rdy) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, issue_ready_o, rdy); end
            checks++; if (valid_vec !== vv) begin errors++; $display("FAIL rnd_valids cyc %0d: got %b want %b", cyc, valid_vec, vv); end
            checks++; if (pending_o !== pend) begin errors++; $display("FAIL rnd_pending cyc %0d: got %h want %h", cyc, pending_o, pend); end
            checks++; if (stall_cnt_o !== m_stall) begin errors++; $display("FAIL rnd_stall cyc %0d: got %0d want %0d", cyc, stall_cnt_o, m_stall); end
            checks++; if (fu_data_o !== m_data) begin errors++; $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, fu_data_o, m_data); end
            model_update(fire, rdy);
            next_clk();
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_basic();
        test_mult_hazard();
        test_lsu_stall();
        test_pending_reuse();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
